// File: rtl/op_stream_decoder.sv
// rtl/op_stream_decoder.sv - registered op word decoder with audio stream and keyboard LED tracking
// Classifies op words into a valid/ready output register and tracks link-reset all-ones runs.
module op_stream_decoder #(
  parameter int OP_WIDTH     = 16,
  parameter int CNT_WIDTH    = 16,
  parameter int IDLE_TIMEOUT = 4096,
  parameter int RESET_RUN    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [OP_WIDTH-1:0]  op,
  input  logic                 op_valid,
  output logic                 op_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2:0]           out_kind,
  output logic [OP_WIDTH-9:0]  out_payload,
  output logic                 audio_active,
  output logic                 audio_44k,
  output logic [CNT_WIDTH-1:0] sample_count,
  output logic [CNT_WIDTH-1:0] drop_count,
  output logic [7:0]           kbd_led,
  output logic                 power_on,
  output logic                 reset_req
);

  localparam int PW = OP_WIDTH - 8;
  localparam int TW = (IDLE_TIMEOUT > 2) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam int RW = $clog2(RESET_RUN + 1);

  typedef enum logic [2:0] {
    K_UNKNOWN  = 3'd0,
    K_START22  = 3'd1,
    K_START44  = 3'd2,
    K_SAMPLE   = 3'd3,
    K_KBD_LED  = 3'd4,
    K_POWER_ON = 3'd5,
    K_ALL_ONES = 3'd6
  } kind_e;

  typedef enum logic {S_IDLE, S_STREAM} state_e;

  state_e               state_q, state_d;
  logic                 out_valid_q, out_valid_d;
  kind_e                kind_q, kind_d, dec_kind;
  logic [PW-1:0]        payload_q, payload_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [RW-1:0]        run_q, run_d;
  logic                 audio_44k_q, audio_44k_d;
  logic [CNT_WIDTH-1:0] sample_q, sample_d;
  logic [CNT_WIDTH-1:0] drop_q, drop_d;
  logic [7:0]           kbd_led_q, kbd_led_d;
  logic                 power_on_q, power_on_d;
  logic                 reset_req_q, reset_req_d;

  logic [7:0]    opcode;
  logic [PW-1:0] payload;
  logic          accept;

  assign opcode   = op[OP_WIDTH-1 -: 8];
  assign payload  = op[PW-1:0];
  assign op_ready = !out_valid_q || out_ready;
  assign accept   = op_valid && op_ready;

  always_comb begin
    dec_kind = K_UNKNOWN;
    if (opcode == 8'hC5 && payload[7:0] == 8'hEF) dec_kind = K_POWER_ON;
    else if (opcode == 8'hC5)                     dec_kind = K_KBD_LED;
    else if (opcode == 8'hC7)                     dec_kind = K_SAMPLE;
    else if (opcode == 8'h1F)                     dec_kind = K_START22;
    else if (opcode == 8'h0F)                     dec_kind = K_START44;
    else if (opcode == 8'hFF)                     dec_kind = K_ALL_ONES;
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    kind_d      = kind_q;
    payload_d   = payload_q;
    timer_d     = timer_q;
    run_d       = run_q;
    audio_44k_d = audio_44k_q;
    sample_d    = sample_q;
    drop_d      = drop_q;
    kbd_led_d   = kbd_led_q;
    power_on_d  = power_on_q;
    reset_req_d = 1'b0;

    if (accept) begin
      out_valid_d = 1'b1;
      kind_d      = dec_kind;
      payload_d   = payload;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (state_q == S_STREAM) begin
      if (timer_q == '0) state_d = S_IDLE;
      else               timer_d = timer_q - 1'b1;
    end

    // Accepted packets override the timer step above, so a sample on expiry keeps the stream.
    if (accept) begin
      if (dec_kind != K_ALL_ONES) run_d = '0;
      case (dec_kind)
        K_START22, K_START44: begin
          state_d     = S_STREAM;
          audio_44k_d = (dec_kind == K_START44);
          sample_d    = '0;
          timer_d     = TW'(IDLE_TIMEOUT - 1);
        end
        K_SAMPLE: begin
          if (state_q == S_STREAM) begin
            state_d = S_STREAM;
            timer_d = TW'(IDLE_TIMEOUT - 1);
            if (sample_q != '1) sample_d = sample_q + 1'b1;
          end else if (drop_q != '1) begin
            drop_d = drop_q + 1'b1;
          end
        end
        K_KBD_LED:  kbd_led_d  = payload[7:0];
        K_POWER_ON: power_on_d = 1'b1;
        K_ALL_ONES: begin
          if (run_q == RW'(RESET_RUN - 1)) begin
            reset_req_d = 1'b1;
            state_d     = S_IDLE;
            sample_d    = '0;
            drop_d      = '0;
            kbd_led_d   = '0;
            power_on_d  = 1'b0;
            run_d       = '0;
          end else begin
            run_d = run_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      kind_q      <= K_UNKNOWN;
      payload_q   <= '0;
      timer_q     <= '0;
      run_q       <= '0;
      audio_44k_q <= 1'b0;
      sample_q    <= '0;
      drop_q      <= '0;
      kbd_led_q   <= '0;
      power_on_q  <= 1'b0;
      reset_req_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      kind_q      <= kind_d;
      payload_q   <= payload_d;
      timer_q     <= timer_d;
      run_q       <= run_d;
      audio_44k_q <= audio_44k_d;
      sample_q    <= sample_d;
      drop_q      <= drop_d;
      kbd_led_q   <= kbd_led_d;
      power_on_q  <= power_on_d;
      reset_req_q <= reset_req_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_kind     = kind_q;
  assign out_payload  = payload_q;
  assign audio_active = (state_q == S_STREAM);
  assign audio_44k    = audio_44k_q;
  assign sample_count = sample_q;
  assign drop_count   = drop_q;
  assign kbd_led      = kbd_led_q;
  assign power_on     = power_on_q;
  assign reset_req    = reset_req_q;

endmodule

// File: tb/tb_op_stream_decoder.sv
// tb/tb_op_stream_decoder.sv - directed-vector bench for op_stream_decoder
// Inputs change and outputs are sampled on the falling edge.
module tb_op_stream_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] op = '0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [2:0]  out_kind;
  logic [7:0]  out_payload;
  logic        audio_active;
  logic        audio_44k;
  logic [15:0] sample_count;
  logic [15:0] drop_count;
  logic [7:0]  kbd_led;
  logic        power_on;
  logic        reset_req;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  op_stream_decoder dut (
    .clk(clk), .reset(reset), .op(op), .op_valid(op_valid), .op_ready(op_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
    .out_payload(out_payload), .audio_active(audio_active), .audio_44k(audio_44k),
    .sample_count(sample_count), .drop_count(drop_count), .kbd_led(kbd_led),
    .power_on(power_on), .reset_req(reset_req)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One-cycle accepted op; returns at the falling edge after the accepting edge.
  task automatic send(input logic [15:0] w);
    @(negedge clk);
    op = w;
    op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_op_ready", op_ready, 1);
    check("rst_active", audio_active, 0);
    check("rst_samples", sample_count, 0);
    reset = 1'b0;

    send(16'h1F00);
    check("t1_valid", out_valid, 1);
    check("t1_kind", out_kind, 1);
    check("t1_active", audio_active, 1);
    check("t1_44k", audio_44k, 0);

    send(16'h0F00);
    check("t2_kind", out_kind, 2);
    check("t2_44k", audio_44k, 1);
    for (int i = 0; i < 3; i++) send(16'hC712);
    check("t2_samples", sample_count, 3);
    check("t2_drops", drop_count, 0);
    check("t2_payload", out_payload, 8'h12);
    repeat (4095) @(negedge clk);
    check("t2_active_4095", audio_active, 1);
    @(negedge clk);
    check("t2_timeout", audio_active, 0);
    check("t2_samples_kept", sample_count, 3);

    send(16'hC712);
    check("t3_drop", drop_count, 1);
    check("t3_kind", out_kind, 3);
    send(16'hC5EF);
    check("t3_pwr_kind", out_kind, 5);
    check("t3_pwr", power_on, 1);
    check("t3_led_kept", kbd_led, 0);
    send(16'hC503);
    check("t3_led", kbd_led, 8'h03);
    check("t3_led_kind", out_kind, 4);

    send(16'hFFFF);
    check("t4_no_req1", reset_req, 0);
    send(16'hFFFF);
    check("t4_req", reset_req, 1);
    check("t4_kind", out_kind, 6);
    check("t4_valid", out_valid, 1);
    check("t4_drop_clr", drop_count, 0);
    check("t4_samp_clr", sample_count, 0);
    check("t4_pwr_clr", power_on, 0);
    check("t4_led_clr", kbd_led, 0);
    @(negedge clk);
    check("t4_req_pulse", reset_req, 0);
    send(16'hFFFF);
    check("t4_run_a", reset_req, 0);
    send(16'hC700);
    check("t4_run_b", reset_req, 0);
    check("t4_run_drop", drop_count, 1);
    send(16'hFFFF);
    check("t4_run_c", reset_req, 0);
    @(negedge clk);
    check("t4_run_d", reset_req, 0);
    check("t4_drained", out_valid, 0);

    out_ready = 1'b0;
    op = 16'h1F34;
    op_valid = 1'b1;
    @(negedge clk);
    check("t5_kind_a", out_kind, 1);
    check("t5_pay_a", out_payload, 8'h34);
    check("t5_stall", op_ready, 0);
    op = 16'h0F56;
    @(negedge clk);
    check("t5_kind_hold", out_kind, 1);
    check("t5_pay_hold", out_payload, 8'h34);
    check("t5_44k_hold", audio_44k, 0);
    check("t5_stall2", op_ready, 0);
    out_ready = 1'b1;
    #1;
    check("t5_ready", op_ready, 1);
    @(negedge clk);
    check("t5_kind_b", out_kind, 2);
    check("t5_pay_b", out_payload, 8'h56);
    check("t5_44k", audio_44k, 1);
    op = 16'hC701;
    @(negedge clk);
    check("t5_kind_c", out_kind, 3);
    check("t5_pay_c", out_payload, 8'h01);
    check("t5_samples", sample_count, 1);
    op_valid = 1'b0;

    repeat (4095) @(negedge clk);
    op = 16'hC702;
    op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    check("t6_stay", audio_active, 1);
    check("t6_samples", sample_count, 2);
    send(16'hC703);
    check("t6_pre_valid", out_valid, 1);
    reset = 1'b1;
    #1;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_active", audio_active, 0);
    check("t6_rst_samples", sample_count, 0);
    check("t6_rst_kind", out_kind, 0);
    check("t6_rst_44k", audio_44k, 0);
    check("t6_rst_ready", op_ready, 1);
    @(negedge clk);
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
